// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, mode bits and capture-edge selection (used by RX and TX).
package spi_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Modes 0/3 sample on the rising SCLK edge, modes 1/2 on the falling edge.
  function automatic logic sel_cap_edge(input spi_mode_t mode, input logic rise, input logic fall);
    return (mode.cpol ^ mode.cpha) ? fall : rise;
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// SCLK rise/fall detector with optional 2-flop input synchronisers (macro SPI_RX_SYNC_EN).
// Without the macro the SPI inputs must already be synchronous to clk_i.
module spi_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic spi_clk_i,
  input  logic spi_rx_i,
  input  logic spi_en_i,
  output logic spi_rx_o,
  output logic spi_en_o,
  output logic rise_o,
  output logic fall_o
);

  logic spi_clk_s;
  logic spi_clk_r_q;

`ifdef SPI_RX_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {spi_clk_i, spi_rx_i, spi_en_i};
      sync2_q <= sync1_q;
    end
  end

  assign {spi_clk_s, spi_rx_o, spi_en_o} = sync2_q;
`else
  assign spi_clk_s = spi_clk_i;
  assign spi_rx_o  = spi_rx_i;
  assign spi_en_o  = spi_en_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spi_clk_r_q <= 1'b0;
    end else begin
      spi_clk_r_q <= spi_clk_s;
    end
  end

  assign rise_o = spi_clk_s & ~spi_clk_r_q;
  assign fall_o = spi_clk_r_q & ~spi_clk_s;

endmodule

// File: rtl/spi_master_rx_deser.sv
// SPI master receive deserialiser: DATA_W-bit words on valid/ready, partial-word flush at frame end.
// Optional macro SPI_RX_SYNC_EN adds input synchronisers (2 clk_i extra latency) for an async SCLK.
module spi_master_rx_deser
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_rx_i,
  input  logic              spi_en_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic [CNT_W-1:0]  rx_bits_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              frame_done_o,
  output logic              overrun_o
);

  localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DATA_W - 1);

  logic spi_rx;
  logic spi_en;
  logic rise;
  logic fall;
  logic cap;

  spi_state_e        state_q;
  spi_mode_t         mode_q;
  logic              lsb_q;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [CNT_W-1:0]  rx_bits_q;
  logic              rx_valid_q;
  logic              frame_done_q;
  logic              overrun_q;

  logic              word_vld;
  logic [DATA_W-1:0] word_dat;
  logic [CNT_W-1:0]  word_bits;
  logic [DATA_W-1:0] part_mask;
  logic [DATA_W-1:0] part_dat;

  spi_edge_det u_edge_det (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .spi_clk_i (spi_clk_i),
    .spi_rx_i  (spi_rx_i),
    .spi_en_i  (spi_en_i),
    .spi_rx_o  (spi_rx),
    .spi_en_o  (spi_en),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  // Partial words are right-aligned; after a full word sh_q keeps stale upper bits, hence the mask.
  always_comb begin
    cap       = sel_cap_edge(mode_q, rise, fall);
    sh_d      = lsb_q ? {spi_rx, sh_q[DATA_W-1:1]} : {sh_q[DATA_W-2:0], spi_rx};
    part_mask = {DATA_W{1'b1}} >> (DW_C - cnt_q);
    part_dat  = lsb_q ? (sh_q >> (DW_C - cnt_q)) : (sh_q & part_mask);

    word_vld  = 1'b0;
    word_dat  = sh_d;
    word_bits = DW_C;
    if (state_q == ST_ACTIVE) begin
      if (!spi_en) begin
        if (cnt_q != '0) begin
          word_vld  = 1'b1;
          word_dat  = part_dat;
          word_bits = cnt_q;
        end
      end else if (cap && (cnt_q == LAST_C)) begin
        word_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_SYNC;
      mode_q       <= '0;
      lsb_q        <= 1'b0;
      sh_q         <= '0;
      cnt_q        <= '0;
      rx_data_q    <= '0;
      rx_bits_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;

      case (state_q)
        ST_SYNC: begin
          if (!spi_en) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (spi_en) begin
            mode_q  <= '{cpol: cpol_i, cpha: cpha_i};
            lsb_q   <= lsb_first_i;
            cnt_q   <= '0;
            sh_q    <= '0;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!spi_en) begin
            frame_done_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
          end else if (cap) begin
            sh_q  <= sh_d;
            cnt_q <= (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_SYNC;
      endcase

      // A word arriving while the held one is still unaccepted is dropped.
      if (word_vld) begin
        if (rx_valid_q && !rx_ready_i) begin
          overrun_q <= 1'b1;
        end else begin
          rx_data_q  <= word_dat;
          rx_bits_q  <= word_bits;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_bits_o    = rx_bits_q;
  assign rx_valid_o   = rx_valid_q;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_spi_master_rx_deser.sv
// Directed bench for spi_master_rx_deser (DATA_W=8, inputs synchronous to clk).
module tb_spi_master_rx_deser;

  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);
  localparam int H  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          miso = 1'b0;
  logic          en = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          lsb = 1'b0;
  logic [DW-1:0] rx_data;
  logic [CW-1:0] rx_bits;
  logic          rx_valid;
  logic          rx_ready = 1'b1;
  logic          frame_done;
  logic          overrun;

  int vec = 0;
  int errs = 0;

  int            cyc = 0;
  logic [DW-1:0] beat_dat[$];
  logic [CW-1:0] beat_bits[$];
  int            beat_cyc[$];
  int            fd_cnt = 0;
  int            fd_cyc = 0;
  int            ov_cnt = 0;

  spi_master_rx_deser #(.DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .spi_clk_i    (sclk),
    .spi_rx_i     (miso),
    .spi_en_i     (en),
    .cpol_i       (cpol),
    .cpha_i       (cpha),
    .lsb_first_i  (lsb),
    .rx_data_o    (rx_data),
    .rx_bits_o    (rx_bits),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .frame_done_o (frame_done),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid && rx_ready) begin
      beat_dat.push_back(rx_data);
      beat_bits.push_back(rx_bits);
      beat_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // First wire bit is bits[nbits-1]; capture edge is the second half of each bit period.
  task automatic send_bits(input logic [31:0] bits, input int nbits);
    logic pre;
    pre = cpol ^ cpha;
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk = pre;
      miso = bits[i];
      tick(H);
      sclk = ~pre;
      tick(H);
    end
  endtask

  task automatic send_frame(input logic m_cpol, input logic m_cpha, input logic m_lsb,
                            input logic [31:0] bits, input int nbits);
    cpol = m_cpol;
    cpha = m_cpha;
    lsb  = m_lsb;
    sclk = m_cpol;
    tick(3);
    en = 1'b1;
    tick(2);
    send_bits(bits, nbits);
    sclk = m_cpol;
    tick(2);
    en = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    vec++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    vec++; if (rx_data !== '0) begin errs++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    vec++; if (rx_bits !== '0) begin errs++; $display("FAIL reset_bits got=%0d exp=0", rx_bits); end
    vec++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_ov got=%b exp=0", overrun); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_mode0_msb;
    int b0, f0, o0;
    b0 = beat_dat.size(); f0 = fd_cnt; o0 = ov_cnt;
    send_frame(1'b0, 1'b0, 1'b0, 32'hA5, 8);
    vec++; if (beat_dat.size() - b0 !== 1) begin errs++; $display("FAIL m0_beats got=%0d exp=1", beat_dat.size() - b0); end
    vec++; if (beat_dat[b0] !== 8'hA5) begin errs++; $display("FAIL m0_data got=%h exp=a5", beat_dat[b0]); end
    vec++; if (beat_bits[b0] !== 4'd8) begin errs++; $display("FAIL m0_bits got=%0d exp=8", beat_bits[b0]); end
    vec++; if (fd_cnt - f0 !== 1) begin errs++; $display("FAIL m0_fd got=%0d exp=1", fd_cnt - f0); end
    vec++; if (ov_cnt - o0 !== 0) begin errs++; $display("FAIL m0_ov got=%0d exp=0", ov_cnt - o0); end
  endtask

  task automatic test_mode3_lsb;
    int b0;
    b0 = beat_dat.size();
    send_frame(1'b1, 1'b1, 1'b1, 32'b00111100, 8);
    vec++; if (beat_dat.size() - b0 !== 1) begin errs++; $display("FAIL m3_beats got=%0d exp=1", beat_dat.size() - b0); end
    vec++; if (beat_dat[b0] !== 8'h3C) begin errs++; $display("FAIL m3_data got=%h exp=3c", beat_dat[b0]); end
    vec++; if (beat_bits[b0] !== 4'd8) begin errs++; $display("FAIL m3_bits got=%0d exp=8", beat_bits[b0]); end
  endtask

  task automatic test_back_to_back(input logic m_cpol, input logic m_cpha);
    int b0, f0;
    b0 = beat_dat.size(); f0 = fd_cnt;
    send_frame(m_cpol, m_cpha, 1'b0, 32'h1234, 16);
    vec++; if (beat_dat.size() - b0 !== 2) begin errs++; $display("FAIL b2b_beats mode=%b%b got=%0d exp=2", m_cpol, m_cpha, beat_dat.size() - b0); end
    vec++; if (beat_dat[b0] !== 8'h12) begin errs++; $display("FAIL b2b_w0 mode=%b%b got=%h exp=12", m_cpol, m_cpha, beat_dat[b0]); end
    vec++; if (beat_dat[b0+1] !== 8'h34) begin errs++; $display("FAIL b2b_w1 mode=%b%b got=%h exp=34", m_cpol, m_cpha, beat_dat[b0+1]); end
    vec++; if (fd_cnt - f0 !== 1 || fd_cyc <= beat_cyc[b0+1]) begin
      errs++; $display("FAIL b2b_fd mode=%b%b count=%0d fd_cyc=%0d beat_cyc=%0d exp one pulse after beat", m_cpol, m_cpha, fd_cnt - f0, fd_cyc, beat_cyc[b0+1]);
    end
  endtask

  task automatic test_partial_msb;
    int b0;
    b0 = beat_dat.size();
    send_frame(1'b0, 1'b0, 1'b0, 32'hABC, 12);
    vec++; if (beat_dat.size() - b0 !== 2) begin errs++; $display("FAIL part_beats got=%0d exp=2", beat_dat.size() - b0); end
    vec++; if (beat_dat[b0] !== 8'hAB || beat_bits[b0] !== 4'd8) begin errs++; $display("FAIL part_w0 got=%h/%0d exp=ab/8", beat_dat[b0], beat_bits[b0]); end
    vec++; if (beat_dat[b0+1] !== 8'h0C) begin errs++; $display("FAIL part_w1_data got=%h exp=0c", beat_dat[b0+1]); end
    vec++; if (beat_bits[b0+1] !== 4'd4) begin errs++; $display("FAIL part_w1_bits got=%0d exp=4", beat_bits[b0+1]); end
    vec++; if (fd_cyc !== beat_cyc[b0+1]) begin errs++; $display("FAIL part_fd_cycle got=%0d exp=%0d", fd_cyc, beat_cyc[b0+1]); end
  endtask

  task automatic test_partial_lsb;
    int b0;
    b0 = beat_dat.size();
    send_frame(1'b0, 1'b1, 1'b1, 32'b1011, 4);
    vec++; if (beat_dat.size() - b0 !== 1) begin errs++; $display("FAIL plsb_beats got=%0d exp=1", beat_dat.size() - b0); end
    vec++; if (beat_dat[b0] !== 8'h0D) begin errs++; $display("FAIL plsb_data got=%h exp=0d", beat_dat[b0]); end
    vec++; if (beat_bits[b0] !== 4'd4) begin errs++; $display("FAIL plsb_bits got=%0d exp=4", beat_bits[b0]); end
  endtask

  task automatic test_overrun;
    int b0, o0;
    b0 = beat_dat.size(); o0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(1'b0, 1'b0, 1'b0, 32'h1122, 16);
    vec++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    vec++; if (rx_data !== 8'h11) begin errs++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
    vec++; if (ov_cnt - o0 !== 1) begin errs++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt - o0); end
    vec++; if (beat_dat.size() - b0 !== 0) begin errs++; $display("FAIL ovr_early_accept got=%0d exp=0", beat_dat.size() - b0); end
    rx_ready = 1'b1;
    tick(3);
    vec++; if (beat_dat.size() - b0 !== 1) begin errs++; $display("FAIL ovr_accepts got=%0d exp=1", beat_dat.size() - b0); end
    vec++; if (beat_dat[b0] !== 8'h11) begin errs++; $display("FAIL ovr_accept_data got=%h exp=11", beat_dat[b0]); end
    vec++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL ovr_valid_after got=%b exp=0", rx_valid); end
  endtask

  task automatic test_rst_midframe;
    int b0, f0;
    b0 = beat_dat.size(); f0 = fd_cnt;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sclk = 1'b0;
    tick(3);
    en = 1'b1;
    tick(2);
    send_bits(32'b101, 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send_bits(32'b11001, 5);
    sclk = 1'b0;
    tick(2);
    en = 1'b0;
    tick(4);
    vec++; if (beat_dat.size() - b0 !== 0) begin errs++; $display("FAIL rst_beats got=%0d exp=0", beat_dat.size() - b0); end
    vec++; if (fd_cnt - f0 !== 0) begin errs++; $display("FAIL rst_fd got=%0d exp=0", fd_cnt - f0); end
    b0 = beat_dat.size();
    send_frame(1'b0, 1'b0, 1'b0, 32'h5A, 8);
    vec++; if (beat_dat.size() - b0 !== 1) begin errs++; $display("FAIL rst_next_beats got=%0d exp=1", beat_dat.size() - b0); end
    vec++; if (beat_dat[b0] !== 8'h5A) begin errs++; $display("FAIL rst_next_data got=%h exp=5a", beat_dat[b0]); end
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_back_to_back(1'b0, 1'b1);
    test_back_to_back(1'b1, 1'b0);
    test_partial_msb();
    test_partial_lsb();
    test_overrun();
    test_rst_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
